// File: rtl/io_stream_responder_if.sv
// Bus and stream signals of the I/O responder: M-stage load/store
// port, TX consumer stream and RX producer stream.
interface io_stream_responder_if #(
    parameter int WIDTH = 36
);
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] writeData;
    logic             writeEnable;
    logic             readEnable;
    logic             hit;
    logic [WIDTH-1:0] readData;
    logic [WIDTH-1:0] txData;
    logic             txValid;
    logic             txReady;
    logic [WIDTH-1:0] rxData;
    logic             rxValid;
    logic             rxReady;

    modport slave (
        input  address, writeData, writeEnable, readEnable, txReady, rxData, rxValid,
        output hit, readData, txData, txValid, rxReady
    );

    modport master (
        output address, writeData, writeEnable, readEnable, txReady, rxData, rxValid,
        input  hit, readData, txData, txValid, rxReady
    );
endinterface

// File: rtl/io_stream_responder.sv
// Memory-mapped I/O responder: stores to TXDATA feed a TX FIFO, loads
// from RXDATA drain a single-entry RX holding register, plus STATUS
// (with sticky W1C error bits) and CONTROL (stream enables).
module io_stream_responder #(
    parameter int               WIDTH    = 36,
    parameter logic [WIDTH-1:0] BASEADDR = 'h100,
    parameter int               DEPTH    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    io_stream_responder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // FIFO state
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    // RX holding register
    logic [WIDTH-1:0] rx_hold_q;
    logic             rx_full_q, rx_full_d;

    // stickies and control
    logic             tx_ovf_q, tx_ovf_d;
    logic             rx_udf_q, rx_udf_d;
    logic             tx_en_q, tx_en_d;
    logic             rx_en_q, rx_en_d;

    // decode
    logic [WIDTH-1:0] offset;
    logic [1:0]       reg_sel;
    logic             tx_full, tx_empty;
    logic             push_req, push_ok, pop;
    logic             rx_cap, rx_pop;
    logic             wr_status, wr_control;
    logic [WIDTH-1:0] status;

    // Offset wraps for addresses below the base, so a single
    // upper-bits-zero test covers both window bounds.
    assign offset  = bus.address - BASEADDR;
    assign reg_sel = offset[1:0];
    assign bus.hit = (offset[WIDTH-1:2] == '0);

    assign tx_full  = (count_q == FULL_CNT);
    assign tx_empty = (count_q == '0);

    assign bus.txValid = tx_en_q & ~tx_empty;
    assign bus.txData  = mem_q[head_q];
    // Reset is folded in so the producer sees no ready while reset is held,
    // even though rx_en_q already holds its reset value of 1.
    assign bus.rxReady = reset & rx_en_q & ~rx_full_q;

    assign pop        = bus.txValid & bus.txReady;
    assign push_req   = bus.hit & bus.writeEnable & (reg_sel == 2'd0);
    assign push_ok    = push_req & (~tx_full | pop);
    assign rx_cap     = bus.rxValid & bus.rxReady;
    assign rx_pop     = bus.hit & bus.readEnable & (reg_sel == 2'd1);
    assign wr_status  = bus.hit & bus.writeEnable & (reg_sel == 2'd2);
    assign wr_control = bus.hit & bus.writeEnable & (reg_sel == 2'd3);

    // STATUS word assembly
    always_comb begin
        status          = '0;
        status[0]       = tx_full;
        status[1]       = tx_empty;
        status[2]       = rx_full_q;
        status[3]       = tx_ovf_q;
        status[4]       = rx_udf_q;
        status[5 +: CW] = count_q;
    end

    // Combinational load data from pre-edge state
    always_comb begin
        bus.readData = '0;
        if (bus.hit) begin
            case (reg_sel)
                2'd1:    bus.readData = rx_full_q ? rx_hold_q : '0;
                2'd2:    bus.readData = status;
                2'd3:    bus.readData[1:0] = {rx_en_q, tx_en_q};
                default: bus.readData = '0;
            endcase
        end
    end

    // Next-state for pointers, count, RX flag, stickies and control
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rx_full_d = rx_full_q;
        tx_ovf_d  = tx_ovf_q;
        rx_udf_d  = rx_udf_q;
        tx_en_d   = tx_en_q;
        rx_en_d   = rx_en_q;

        if (push_ok) tail_d = tail_q + PW'(1);
        if (pop)     head_d = head_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error event in the same cycle as a clear wins.
        if (wr_status && bus.writeData[3]) tx_ovf_d = 1'b0;
        if (wr_status && bus.writeData[4]) rx_udf_d = 1'b0;
        if (push_req && !push_ok)          tx_ovf_d = 1'b1;

        if (rx_pop) begin
            if (rx_full_q) rx_full_d = 1'b0;
            else           rx_udf_d  = 1'b1;
        end
        // Capture only happens while empty, so it never races a clearing pop.
        if (rx_cap) rx_full_d = 1'b1;

        if (wr_control) begin
            tx_en_d = bus.writeData[0];
            rx_en_d = bus.writeData[1];
        end
    end

    // Control/state registers, asynchronously reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rx_full_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            tx_en_q   <= 1'b1;
            rx_en_q   <= 1'b1;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rx_full_q <= rx_full_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_udf_q  <= rx_udf_d;
            tx_en_q   <= tx_en_d;
            rx_en_q   <= rx_en_d;
        end
    end

    // Data storage; validity is tracked by count/rx_full, so no reset needed
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[tail_q] <= bus.writeData;
        if (rx_cap)  rx_hold_q     <= bus.rxData;
    end
endmodule

// File: tb/tb_io_stream_responder.sv
// Scoreboard bench for io_stream_responder: expected TX words and load
// results are queued by the stimulus and checked by a negedge monitor.
module tb_io_stream_responder;
    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [35:0] tx_q[$];
    logic [35:0] rd_q[$];

    io_stream_responder_if #(.WIDTH(36)) bus ();

    io_stream_responder #(.WIDTH(36), .BASEADDR(36'h100), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Monitor: sample away from the rising edge
    always @(negedge clock) begin
        if (bus.readEnable) begin
            if (rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected: got 'h%0h expected no load", bus.readData);
            end else begin
                chk("load_data", bus.readData, rd_q.pop_front());
            end
        end
        if (bus.txValid && bus.txReady) begin
            if (tx_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected: got 'h%0h expected no word", bus.txData);
            end else begin
                chk("tx_word", bus.txData, tx_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [35:0] a, input logic [35:0] d);
        bus.address = a; bus.writeData = d; bus.writeEnable = 1'b1;
        @(posedge clock); #1;
        bus.writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [35:0] a, input logic [35:0] exp);
        bus.address = a; bus.readEnable = 1'b1;
        rd_q.push_back(exp);
        @(posedge clock); #1;
        bus.readEnable = 1'b0;
    endtask

    task automatic push(input logic [35:0] d);
        tx_q.push_back(d);
        wr(36'h100, d);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (tx_q.size() != 0 && n < 50) begin
            @(posedge clock); n++;
        end
        #1;
        chk({"drain_", name}, 36'(tx_q.size()), 36'h0);
        chk({"txvalid_idle_", name}, {35'h0, bus.txValid}, 36'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.address = '0; bus.writeData = '0; bus.writeEnable = 1'b0;
        bus.readEnable = 1'b0; bus.txReady = 1'b0;
        bus.rxData = '0; bus.rxValid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rxready_in_reset", {35'h0, bus.rxReady}, 36'h0);
        chk("txvalid_in_reset", {35'h0, bus.txValid}, 36'h0);
        reset = 1'b1;
        #1;
        chk("rxready_after_reset", {35'h0, bus.rxReady}, 36'h1);
        chk("txvalid_after_reset", {35'h0, bus.txValid}, 36'h0);
        @(posedge clock); #1;
        rd(36'h102, 36'h2);

        // Fill FIFO with consumer stalled, then overflow
        push(36'hA); push(36'hB); push(36'hC); push(36'hD);
        rd(36'h102, 36'h81);
        wr(36'h100, 36'hE);
        rd(36'h102, 36'h89);
        wr(36'h102, 36'h8);
        rd(36'h102, 36'h81);

        // Full FIFO, push with same-cycle pop
        bus.address = 36'h100; bus.writeData = 36'h55; bus.writeEnable = 1'b1;
        bus.txReady = 1'b1;
        tx_q.push_back(36'h55);
        @(posedge clock); #1;
        bus.writeEnable = 1'b0; bus.txReady = 1'b0;
        rd(36'h102, 36'h81);
        bus.txReady = 1'b1;
        wait_drain("fifo");
        rd(36'h102, 36'h2);

        // RX capture, pop, underflow, W1C
        bus.rxData = 36'h123; bus.rxValid = 1'b1;
        @(posedge clock); #1;
        bus.rxValid = 1'b0;
        chk("rxready_full", {35'h0, bus.rxReady}, 36'h0);
        rd(36'h102, 36'h6);
        rd(36'h101, 36'h123);
        chk("rxready_after_pop", {35'h0, bus.rxReady}, 36'h1);
        rd(36'h101, 36'h0);
        rd(36'h102, 36'h12);
        wr(36'h102, 36'h18);
        rd(36'h102, 36'h2);

        // Control gating
        bus.txReady = 1'b0;
        push(36'h21); push(36'h22);
        wr(36'h103, 36'h0);
        chk("txvalid_disabled", {35'h0, bus.txValid}, 36'h0);
        chk("rxready_disabled", {35'h0, bus.rxReady}, 36'h0);
        rd(36'h103, 36'h0);
        bus.txReady = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("stalled_count", 36'(tx_q.size()), 36'h2);
        wr(36'h103, 36'h3);
        wait_drain("ctrl");
        rd(36'h103, 36'h3);

        // Reset mid-drain with 3 words queued
        bus.txReady = 1'b0;
        push(36'h31); push(36'h32); push(36'h33);
        bus.txReady = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
        #1;
        chk("txvalid_reset_drop", {35'h0, bus.txValid}, 36'h0);
        chk("rxready_reset_drop", {35'h0, bus.rxReady}, 36'h0);
        tx_q.delete();
        bus.txReady = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        rd(36'h102, 36'h2);

        // Out-of-window strobes
        bus.address = 36'h104; bus.writeData = 36'h7;
        #1;
        chk("hit_104", {35'h0, bus.hit}, 36'h0);
        wr(36'h104, 36'h7);
        rd(36'h104, 36'h0);
        bus.address = 36'hFF;
        #1;
        chk("hit_ff", {35'h0, bus.hit}, 36'h0);
        wr(36'hFF, 36'h7);
        rd(36'hFF, 36'h0);
        bus.address = 36'h103;
        #1;
        chk("hit_103", {35'h0, bus.hit}, 36'h1);
        rd(36'h102, 36'h2);
        chk("txvalid_end", {35'h0, bus.txValid}, 36'h0);
        chk("rd_q_empty", 36'(rd_q.size()), 36'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
